// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute-to-memory pipeline stage
// Resolves branches, runs load/store on the data-memory req/ack port and registers WB results.
module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        flush,
    input  logic [31:0] ex_result,
    input  logic        ex_zero,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_branch,
    input  logic [31:0] ex_branch_target,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_fault
);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  mem_rd_q, mem_rd_d;
    logic        mem_rw_q, mem_rw_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        branch_taken_q, branch_taken_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic        misalign_fault_q, misalign_fault_d;

    logic        accept;
    logic        is_mem;
    logic [1:0]  ex_size;
    logic [1:0]  ex_lane;
    logic        misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;
    assign is_mem   = ex_mem_read | ex_mem_write;
    assign ex_lane  = ex_result[1:0];

    // Reserved funct3 encodings fall through to word size.
    always_comb begin
        ex_size = SZ_WORD;
        case (ex_funct3)
            3'b000, 3'b100: ex_size = SZ_BYTE;
            3'b001, 3'b101: ex_size = SZ_HALF;
            default:        ex_size = SZ_WORD;
        endcase
    end

    assign misaligned = ((ex_size == SZ_HALF) & ex_lane[0]) |
                        ((ex_size == SZ_WORD) & (ex_lane != 2'b00));

    always_comb begin
        st_strb = 4'b1111;
        st_data = ex_store_data;
        case (ex_size)
            SZ_BYTE: begin
                st_strb = 4'b0001 << ex_lane;
                st_data = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                st_strb = 4'b0011 << ex_lane;
                st_data = {2{ex_store_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = ex_store_data;
            end
        endcase
    end

    // Aligned accesses guarantee the selected lane lands at bit 0 after this shift.
    assign rdata_shifted = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_data = rdata_shifted;
        case (size_q)
            SZ_BYTE: load_data = unsigned_q ? {24'h0, rdata_shifted[7:0]}
                                            : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_HALF: load_data = unsigned_q ? {16'h0, rdata_shifted[15:0]}
                                            : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        dmem_req_d       = dmem_req_q;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        dmem_wstrb_d     = dmem_wstrb_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        lane_d           = lane_q;
        mem_rd_d         = mem_rd_q;
        mem_rw_d         = mem_rw_q;
        wb_valid_d       = 1'b0;
        wb_reg_write_d   = wb_reg_write_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        branch_taken_d   = 1'b0;
        branch_target_d  = branch_target_q;
        misalign_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem && misaligned) begin
                        wb_valid_d       = 1'b1;
                        wb_reg_write_d   = 1'b0;
                        wb_rd_d          = ex_rd;
                        wb_data_d        = ex_result;
                        misalign_fault_d = 1'b1;
                    end else if (is_mem) begin
                        state_d      = MEM_WAIT;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex_mem_write;
                        dmem_addr_d  = {ex_result[31:2], 2'b00};
                        dmem_wdata_d = ex_mem_write ? st_data : 32'h0;
                        dmem_wstrb_d = ex_mem_write ? st_strb : 4'b0000;
                        size_d       = ex_size;
                        unsigned_d   = ex_funct3[2];
                        lane_d       = ex_lane;
                        mem_rd_d     = ex_rd;
                        mem_rw_d     = ~ex_mem_write & ex_reg_write & (ex_rd != 5'd0);
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_result;
                        wb_reg_write_d = ex_reg_write & (ex_rd != 5'd0) & ~ex_branch;
                        if (ex_branch && ex_zero) begin
                            branch_taken_d  = 1'b1;
                            branch_target_d = ex_branch_target;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = mem_rd_q;
                    wb_reg_write_d = mem_rw_q;
                    wb_data_d      = dmem_we_q ? 32'h0 : load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= 32'h0;
            dmem_wdata_q     <= 32'h0;
            dmem_wstrb_q     <= 4'b0000;
            size_q           <= SZ_BYTE;
            unsigned_q       <= 1'b0;
            lane_q           <= 2'b00;
            mem_rd_q         <= 5'd0;
            mem_rw_q         <= 1'b0;
            wb_valid_q       <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_data_q        <= 32'h0;
            branch_taken_q   <= 1'b0;
            branch_target_q  <= 32'h0;
            misalign_fault_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            dmem_req_q       <= dmem_req_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            dmem_wstrb_q     <= dmem_wstrb_d;
            size_q           <= size_d;
            unsigned_q       <= unsigned_d;
            lane_q           <= lane_d;
            mem_rd_q         <= mem_rd_d;
            mem_rw_q         <= mem_rw_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            branch_taken_q   <= branch_taken_d;
            branch_target_q  <= branch_target_d;
            misalign_fault_q <= misalign_fault_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign branch_taken   = branch_taken_q;
    assign branch_target  = branch_target_q;
    assign misalign_fault = misalign_fault_q;

endmodule
